// File: rtl/axi_burst_scheduler_pkg.sv
// Shared AXI encodings, the 4 KB page size and the FSM state type for the burst scheduler.
package axi_burst_scheduler_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'd1;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'd0;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;
    localparam logic [1:0] AXI_RESP_DECERR = 2'd3;

    localparam int unsigned PAGE_BYTES = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_ISSUE,
        ST_DRAIN
    } state_t;

    function automatic logic [31:0] min32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_burst_split.sv
// Sizes the next burst: bytes to issue (4 KB and MAX_BEATS limited), beat count,
// and the byte strobe for the last beat of the whole transfer.
module axi_burst_split
    import axi_burst_scheduler_pkg::*;
#(
    parameter int DATA_WBITS = 512,
    parameter int MAX_BEATS  = 256
) (
    input  logic [11:0]             addr_lo,
    input  logic [31:0]             remaining,
    output logic [31:0]             bb,
    output logic [8:0]              beats,
    output logic [DATA_WBITS/8-1:0] tail_strb
);
    localparam int DBYTES = DATA_WBITS / 8;
    localparam int ASZ    = $clog2(DBYTES);
    localparam logic [31:0] MAX_BYTES = 32'(MAX_BEATS * DBYTES);

    logic [31:0] to_4k;
    logic [31:0] rounded;

    always_comb begin
        to_4k   = 32'(PAGE_BYTES) - {20'd0, addr_lo};
        bb      = min32(min32(remaining, to_4k), MAX_BYTES);
        rounded = bb + 32'(DBYTES - 1);
        beats   = 9'(rounded >> ASZ);
        tail_strb = '1;
        // A transfer that is not a whole number of beats keeps only the low bytes on its final beat.
        if (remaining[ASZ-1:0] != '0) begin
            for (int i = 0; i < DBYTES; i++) begin
                if (i >= int'(remaining[ASZ-1:0])) tail_strb[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_burst_scheduler.sv
// AXI4 write master: splits one command into INCR bursts, streams a counting
// data pattern on W and retires B responses with a bounded outstanding count.
module axi_burst_scheduler
    import axi_burst_scheduler_pkg::*;
#(
    parameter int DATA_WBITS      = 512,
    parameter int MAX_BEATS       = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [63:0]             cmd_addr,
    input  logic [31:0]             cmd_bytes,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    bresp_err,
    output logic [63:0]             M_AXI_AWADDR,
    output logic [7:0]              M_AXI_AWLEN,
    output logic [2:0]              M_AXI_AWSIZE,
    output logic [1:0]              M_AXI_AWBURST,
    output logic                    M_AXI_AWVALID,
    input  logic                    M_AXI_AWREADY,
    output logic [DATA_WBITS-1:0]   M_AXI_WDATA,
    output logic [DATA_WBITS/8-1:0] M_AXI_WSTRB,
    output logic                    M_AXI_WLAST,
    output logic                    M_AXI_WVALID,
    input  logic                    M_AXI_WREADY,
    input  logic [1:0]              M_AXI_BRESP,
    input  logic                    M_AXI_BVALID,
    output logic                    M_AXI_BREADY
);
    localparam int DBYTES = DATA_WBITS / 8;
    localparam int ASZ    = $clog2(DBYTES);
    localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

    state_t state, state_nxt;

    logic [63:0]       addr_q, awaddr_q;
    logic [31:0]       rem_q, bb_q, beat_cnt;
    logic [7:0]        awlen_q, burst_cnt;
    logic [DBYTES-1:0] tail_strb_q;
    logic              last_burst_q;
    logic              awvalid_q, wvalid_q, aw_done, w_done;
    logic [3:0]        outstanding;
    logic              done_q, busy_q, err_q;

    logic [31:0]       bb_c;
    logic [8:0]        beats_c;
    logic [DBYTES-1:0] tail_c;

    logic cmd_accept, aw_hs, w_hs, wlast, burst_end, calc_go, b_dec, drain_exit;
    logic unused_addr_lsb;

    assign unused_addr_lsb = ^cmd_addr[ASZ-1:0];

    axi_burst_split #(
        .DATA_WBITS (DATA_WBITS),
        .MAX_BEATS  (MAX_BEATS)
    ) u_split (
        .addr_lo   (addr_q[11:0]),
        .remaining (rem_q),
        .bb        (bb_c),
        .beats     (beats_c),
        .tail_strb (tail_c)
    );

    assign cmd_accept = cmd_valid && (state == ST_IDLE);
    assign aw_hs      = awvalid_q && M_AXI_AWREADY;
    assign w_hs       = wvalid_q && M_AXI_WREADY;
    assign wlast      = (burst_cnt == awlen_q);
    // AW and W complete independently; the burst ends once both have.
    assign burst_end  = (state == ST_ISSUE) && (aw_done || aw_hs) && (w_done || (w_hs && wlast));
    assign calc_go    = (state == ST_CALC) && (outstanding != OUT_MAX);
    assign b_dec      = M_AXI_BVALID && (outstanding != 4'd0);
    assign drain_exit = (state == ST_DRAIN) && (outstanding == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (cmd_accept && cmd_bytes != 32'd0) state_nxt = ST_CALC;
            ST_CALC:  if (calc_go) state_nxt = ST_ISSUE;
            ST_ISSUE: if (burst_end) state_nxt = (rem_q != bb_q) ? ST_CALC : ST_DRAIN;
            ST_DRAIN: if (drain_exit) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q       <= '0;
            awaddr_q     <= '0;
            rem_q        <= '0;
            bb_q         <= '0;
            beat_cnt     <= '0;
            awlen_q      <= '0;
            burst_cnt    <= '0;
            tail_strb_q  <= '1;
            last_burst_q <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            outstanding  <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (M_AXI_BVALID && M_AXI_BRESP != AXI_RESP_OKAY) err_q <= 1'b1;
            if (cmd_accept) begin
                addr_q   <= {cmd_addr[63:ASZ], ASZ'(0)};
                rem_q    <= cmd_bytes;
                beat_cnt <= '0;
                err_q    <= 1'b0;
                if (cmd_bytes == 32'd0) done_q <= 1'b1;
                else                    busy_q <= 1'b1;
            end
            if (calc_go) begin
                awaddr_q     <= addr_q;
                awlen_q      <= 8'(beats_c - 9'd1);
                bb_q         <= bb_c;
                tail_strb_q  <= tail_c;
                last_burst_q <= (bb_c == rem_q);
                burst_cnt    <= '0;
                awvalid_q    <= 1'b1;
                wvalid_q     <= 1'b1;
                aw_done      <= 1'b0;
                w_done       <= 1'b0;
            end
            if (aw_hs) begin
                awvalid_q <= 1'b0;
                aw_done   <= 1'b1;
            end
            if (w_hs) begin
                beat_cnt <= beat_cnt + 32'd1;
                if (wlast) begin
                    wvalid_q <= 1'b0;
                    w_done   <= 1'b1;
                end else begin
                    burst_cnt <= burst_cnt + 8'd1;
                end
            end
            if (burst_end) begin
                addr_q <= addr_q + {32'd0, bb_q};
                rem_q  <= rem_q - bb_q;
            end
            case ({burst_end, b_dec})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
            if (drain_exit) begin
                done_q <= 1'b1;
                busy_q <= 1'b0;
            end
        end
    end

    assign cmd_ready     = (state == ST_IDLE);
    assign busy          = busy_q;
    assign done          = done_q;
    assign bresp_err     = err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWLEN   = awlen_q;
    assign M_AXI_AWSIZE  = 3'(ASZ);
    assign M_AXI_AWBURST = AXI_BURST_INCR;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = DATA_WBITS'(beat_cnt);
    assign M_AXI_WSTRB   = (last_burst_q && wlast) ? tail_strb_q : '1;
    assign M_AXI_WLAST   = wlast;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = 1'b1;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Directed bench for axi_burst_scheduler: an AXI slave model records AW/W beats
// and returns B responses; the main sequence checks bursts against hand-computed values.
module tb_axi_burst_scheduler;
    localparam int DW = 512;
    localparam int DB = DW / 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [63:0]   cmd_addr = '0;
    logic [31:0]   cmd_bytes = '0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready, busy, done, bresp_err;
    logic [63:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          awvalid, awready;
    logic [DW-1:0] wdata;
    logic [DB-1:0] wstrb;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;

    axi_burst_scheduler #(
        .DATA_WBITS      (DW),
        .MAX_BEATS       (256),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_addr      (cmd_addr),
        .cmd_bytes     (cmd_bytes),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .busy          (busy),
        .done          (done),
        .bresp_err     (bresp_err),
        .M_AXI_AWADDR  (awaddr),
        .M_AXI_AWLEN   (awlen),
        .M_AXI_AWSIZE  (awsize),
        .M_AXI_AWBURST (awburst),
        .M_AXI_AWVALID (awvalid),
        .M_AXI_AWREADY (awready),
        .M_AXI_WDATA   (wdata),
        .M_AXI_WSTRB   (wstrb),
        .M_AXI_WLAST   (wlast),
        .M_AXI_WVALID  (wvalid),
        .M_AXI_WREADY  (wready),
        .M_AXI_BRESP   (bresp),
        .M_AXI_BVALID  (bvalid),
        .M_AXI_BREADY  (bready)
    );

    always #5 clk = ~clk;

    logic [63:0] aw_addr_a [0:4095];
    logic [7:0]  aw_len_a  [0:4095];
    logic [31:0] w_data_a  [0:4095];
    logic [63:0] w_strb_a  [0:4095];
    logic        w_last_a  [0:4095];
    logic [1:0]  bresp_tab [0:63];
    int aw_n = 0, w_n = 0, done_cnt = 0, b_idx = 0, b_pending = 0;
    bit b_hold = 1'b0, wready_rand = 1'b0, slave_clear = 1'b0;
    int n_assert = 0, n_fail = 0;

    // Slave: drives ready/B on the falling edge, records handshakes due at the next rising edge.
    initial begin
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'd0;
        forever begin
            @(negedge clk);
            if (slave_clear) begin
                b_pending = 0; bvalid = 1'b0; bresp = 2'd0;
            end else if (!b_hold && b_pending > 0) begin
                bvalid = 1'b1; bresp = bresp_tab[b_idx % 64]; b_idx++; b_pending--;
            end else begin
                bvalid = 1'b0; bresp = 2'd0;
            end
            wready = wready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (!reset) begin
                if (awvalid && awready && aw_n < 4096) begin
                    aw_addr_a[aw_n] = awaddr; aw_len_a[aw_n] = awlen; aw_n++;
                end
                if (wvalid && wready && w_n < 4096) begin
                    w_data_a[w_n] = wdata[31:0]; w_strb_a[w_n] = wstrb; w_last_a[w_n] = wlast;
                    if (wlast) b_pending++;
                    w_n++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [63:0] a, input logic [31:0] b);
        cmd_addr = a; cmd_bytes = b; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(done), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int a0, w0, d0;
        for (int i = 0; i < 64; i++) bresp_tab[i] = 2'd0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("rst_awvalid", 64'(awvalid), 64'd0);
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_bresp_err", 64'(bresp_err), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // single 4-beat burst
        a0 = aw_n; w0 = w_n;
        send_cmd(64'h1000, 32'd256);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_cmd_ready", 64'(cmd_ready), 64'd0);
        wait_done("t1_done", 200);
        chk("t1_busy_after", 64'(busy), 64'd0);
        chk("t1_aw_count", 64'(aw_n - a0), 64'd1);
        chk("t1_awaddr", aw_addr_a[a0], 64'h1000);
        chk("t1_awlen", 64'(aw_len_a[a0]), 64'd3);
        chk("t1_awsize", 64'(awsize), 64'd6);
        chk("t1_awburst", 64'(awburst), 64'd1);
        chk("t1_bready", 64'(bready), 64'd1);
        chk("t1_w_count", 64'(w_n - w0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_wdata%0d", i), 64'(w_data_a[w0+i]), 64'(i));
            chk($sformatf("t1_wstrb%0d", i), w_strb_a[w0+i], 64'hFFFF_FFFF_FFFF_FFFF);
            chk($sformatf("t1_wlast%0d", i), 64'(w_last_a[w0+i]), 64'(i == 3));
        end

        // zero-length command
        a0 = aw_n;
        send_cmd(64'h40, 32'd0);
        chk("t0_done", 64'(done), 64'd1);
        chk("t0_busy", 64'(busy), 64'd0);
        tick(3);
        chk("t0_done_pulse", 64'(done), 64'd0);
        chk("t0_no_aw", 64'(aw_n - a0), 64'd0);

        // 4 KB split
        a0 = aw_n; w0 = w_n;
        send_cmd(64'h0FC0, 32'd128);
        wait_done("t2_done", 200);
        chk("t2_aw_count", 64'(aw_n - a0), 64'd2);
        chk("t2_awaddr0", aw_addr_a[a0], 64'h0FC0);
        chk("t2_awaddr1", aw_addr_a[a0+1], 64'h1000);
        chk("t2_awlen0", 64'(aw_len_a[a0]), 64'd0);
        chk("t2_awlen1", 64'(aw_len_a[a0+1]), 64'd0);
        chk("t2_wdata0", 64'(w_data_a[w0]), 64'd0);
        chk("t2_wdata1", 64'(w_data_a[w0+1]), 64'd1);
        chk("t2_wlast1", 64'(w_last_a[w0+1]), 64'd1);

        // partial final beat: 100 bytes = 64 + 36
        a0 = aw_n; w0 = w_n;
        send_cmd(64'h0, 32'd100);
        wait_done("t3_done", 200);
        chk("t3_awlen", 64'(aw_len_a[a0]), 64'd1);
        chk("t3_wstrb0", w_strb_a[w0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t3_wstrb1", w_strb_a[w0+1], 64'h0000_000F_FFFF_FFFF);
        chk("t3_wlast1", 64'(w_last_a[w0+1]), 64'd1);

        // 64 KB with B withheld: stalls after two outstanding bursts
        a0 = aw_n; w0 = w_n; d0 = done_cnt;
        b_hold = 1'b1;
        send_cmd(64'h0, 32'd65536);
        tick(400);
        chk("t4_stall_aw_count", 64'(aw_n - a0), 64'd2);
        chk("t4_stall_w_count", 64'(w_n - w0), 64'd128);
        chk("t4_awlen0", 64'(aw_len_a[a0]), 64'd63);
        chk("t4_awaddr1", aw_addr_a[a0+1], 64'h1000);
        chk("t4_stall_busy", 64'(busy), 64'd1);
        chk("t4_stall_awvalid", 64'(awvalid), 64'd0);
        chk("t4_stall_no_done", 64'(done_cnt - d0), 64'd0);
        b_hold = 1'b0;
        wait_done("t4_done", 3000);
        chk("t4_aw_count", 64'(aw_n - a0), 64'd16);
        chk("t4_w_count", 64'(w_n - w0), 64'd1024);
        chk("t4_awaddr15", aw_addr_a[a0+15], 64'hF000);
        chk("t4_wdata_last", 64'(w_data_a[w0+1023]), 64'd1023);
        chk("t4_wstrb_last", w_strb_a[w0+1023], 64'hFFFF_FFFF_FFFF_FFFF);
        tick(20);
        chk("t4_done_once", 64'(done_cnt - d0), 64'd1);

        // second burst answers SLVERR; the next command clears the flag
        a0 = aw_n;
        bresp_tab[(b_idx + 1) % 64] = 2'd2;
        send_cmd(64'h0, 32'd8192);
        wait_done("t5_done", 400);
        chk("t5_aw_count", 64'(aw_n - a0), 64'd2);
        chk("t5_bresp_err", 64'(bresp_err), 64'd1);
        for (int i = 0; i < 64; i++) bresp_tab[i] = 2'd0;
        send_cmd(64'h2000, 32'd64);
        chk("t5_err_cleared", 64'(bresp_err), 64'd0);
        wait_done("t5b_done", 200);
        chk("t5b_bresp_err", 64'(bresp_err), 64'd0);

        // reset in the middle of a burst with a stuttering WREADY
        wready_rand = 1'b1;
        send_cmd(64'h0, 32'd4096);
        tick(10);
        chk("t6_in_issue", 64'(wvalid), 64'd1);
        reset = 1'b1;
        tick(1);
        chk("t6_rst_awvalid", 64'(awvalid), 64'd0);
        chk("t6_rst_wvalid", 64'(wvalid), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        slave_clear = 1'b1;
        tick(2);
        reset = 1'b0;
        slave_clear = 1'b0;
        wready_rand = 1'b0;
        tick(1);
        a0 = aw_n; w0 = w_n;
        send_cmd(64'h3000, 32'd128);
        wait_done("t6_done", 200);
        chk("t6_aw_count", 64'(aw_n - a0), 64'd1);
        chk("t6_awaddr", aw_addr_a[a0], 64'h3000);
        chk("t6_awlen", 64'(aw_len_a[a0]), 64'd1);
        chk("t6_wdata0", 64'(w_data_a[w0]), 64'd0);
        chk("t6_wdata1", 64'(w_data_a[w0+1]), 64'd1);
        chk("t6_wlast0", 64'(w_last_a[w0]), 64'd0);
        chk("t6_bresp_err", 64'(bresp_err), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
